// File: rtl/ps2_key_event_fifo.sv
// PS/2 scan-code parser folding E0/F0 prefixes into 10-bit key events, buffered in a FWFT FIFO.
// Optional typematic repeat filter: define PS2_REPEAT_FILTER_EN.
module ps2_key_event_fifo #(
   parameter int          DEPTH_LOG2     = 3,
   parameter logic [15:0] PREFIX_TIMEOUT = 16'd50000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [7:0]            ps2_key_data,
   input  logic                  ps2_key_pressed,
   input  logic                  rd_en,
   output logic [9:0]            rd_data,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  irq,
   output logic                  overflow,
   input  logic                  clr_overflow,
   output logic [7:0]            last_make
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0} state_t;

   state_t                state_q, state_d;
   logic [15:0]           tmo_q, tmo_d;
   logic [9:0]            mem_q [DEPTH];
   logic [9:0]            mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic [7:0]            last_make_q, last_make_d;

   logic                  ev_valid_s, repeat_s, push_req_s;
   logic [9:0]            ev_s;
   logic                  full_s, do_push_s, do_pop_s, drop_s;

   always_comb begin
      state_d    = state_q;
      tmo_d      = tmo_q;
      ev_valid_s = 1'b0;
      ev_s       = {2'b00, ps2_key_data};
      if (ps2_key_pressed) begin
         tmo_d = 16'd0;
         case (state_q)
            ST_IDLE: begin
               case (ps2_key_data)
                  8'hE0:                                    state_d = ST_E0;
                  8'hF0:                                    state_d = ST_F0;
                  8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: state_d = ST_IDLE;
                  default: begin
                     ev_valid_s = 1'b1;
                     ev_s       = {2'b00, ps2_key_data};
                  end
               endcase
            end
            ST_E0: begin
               case (ps2_key_data)
                  8'hF0:   state_d = ST_E0F0;
                  8'hE0:   state_d = ST_E0;
                  default: begin
                     ev_valid_s = 1'b1;
                     ev_s       = {2'b01, ps2_key_data};
                     state_d    = ST_IDLE;
                  end
               endcase
            end
            ST_F0: begin
               case (ps2_key_data)
                  8'hE0:   state_d = ST_E0;
                  8'hF0:   state_d = ST_F0;
                  default: begin
                     ev_valid_s = 1'b1;
                     ev_s       = {2'b10, ps2_key_data};
                     state_d    = ST_IDLE;
                  end
               endcase
            end
            ST_E0F0: begin
               case (ps2_key_data)
                  8'hE0:   state_d = ST_E0;
                  8'hF0:   state_d = ST_E0F0;
                  default: begin
                     ev_valid_s = 1'b1;
                     ev_s       = {2'b11, ps2_key_data};
                     state_d    = ST_IDLE;
                  end
               endcase
            end
            default: state_d = ST_IDLE;
         endcase
      end else if (state_q != ST_IDLE) begin
         // A prefix with no follow-up byte is abandoned silently.
         if (tmo_q == PREFIX_TIMEOUT - 16'd1) begin
            state_d = ST_IDLE;
            tmo_d   = 16'd0;
         end else begin
            tmo_d = tmo_q + 16'd1;
         end
      end else begin
         tmo_d = 16'd0;
      end
   end

`ifdef PS2_REPEAT_FILTER_EN
   logic [9:0] held_q, held_d;
   logic       held_match_s;

   always_comb begin
      held_match_s = held_q[9] && (held_q[8:0] == ev_s[8:0]);
      repeat_s     = ev_valid_s && !ev_s[9] && held_match_s;
      held_d       = held_q;
      if (do_push_s && !ev_s[9]) begin
         held_d = {1'b1, ev_s[8:0]};
      end else if (ev_valid_s && ev_s[9] && held_match_s) begin
         held_d = 10'h000;
      end else begin
         held_d = held_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) held_q <= 10'h000;
      else       held_q <= held_d;
   end
`else
   assign repeat_s = 1'b0;
`endif

   assign push_req_s = ev_valid_s && !repeat_s;
   assign full_s     = (count_q == FULL_CNT);
   assign do_pop_s   = rd_en && (count_q != {(DEPTH_LOG2+1){1'b0}});
   // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
   assign do_push_s  = push_req_s && (!full_s || do_pop_s);
   assign drop_s     = push_req_s && full_s && !do_pop_s;

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      last_make_d = last_make_q;
      overflow_d  = overflow_q;
      if (do_push_s) begin
         mem_d[wr_ptr_q] = ev_s;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
         if (!ev_s[9]) last_make_d = ev_s[7:0];
         else          last_make_d = last_make_q;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) rd_ptr_d = rd_ptr_q + PTR_ONE;
      else          rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (drop_s)            overflow_d = 1'b1;
      else if (clr_overflow) overflow_d = 1'b0;
      else                   overflow_d = overflow_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         tmo_q       <= 16'd0;
         wr_ptr_q    <= {DEPTH_LOG2{1'b0}};
         rd_ptr_q    <= {DEPTH_LOG2{1'b0}};
         count_q     <= {(DEPTH_LOG2+1){1'b0}};
         overflow_q  <= 1'b0;
         last_make_q <= 8'h00;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 10'h000;
      end else begin
         state_q     <= state_d;
         tmo_q       <= tmo_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         last_make_q <= last_make_d;
         mem_q       <= mem_d;
      end
   end

   assign rd_data   = mem_q[rd_ptr_q];
   assign count     = count_q;
   assign empty     = (count_q == {(DEPTH_LOG2+1){1'b0}});
   assign full      = full_s;
   assign irq       = ~empty;
   assign overflow  = overflow_q;
   assign last_make = last_make_q;

endmodule
